hog_buffer_reader: RTL and testbench

Read-side sequencer for the HOG descriptor buffer. After the buffer reports a complete 3780-word descriptor, this block sweeps the buffer's read address from 0 to 3779. It captures each 32-bit bin value and streams it, with its feature index, to the SVM dot-product unit over a valid/ready handshake. It sits between the HOG buffer (asynchronous, combinational read port) and the SVM classifier.

---
 rtl/hog_pkg.sv | 21 ++
 rtl/hog_buffer_reader.sv | 142 ++++++++++++++
 tb/tb_hog_buffer_reader.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hog_pkg.sv
// -----------------------------------------------------------------------------
// hog_pkg
// Shared constants and types for the HOG descriptor buffer and its readers /
// writers. The descriptor is a fixed-length vector of 3780 32-bit bins built
// from 36-bin blocks.
// -----------------------------------------------------------------------------
package hog_pkg;

   localparam int N_FEAT  = 3780;
   localparam int BLK_LEN = 36;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 12;

   // Read-side sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } hogState_t;

endpackage

// File: rtl/hog_buffer_reader.sv
// -----------------------------------------------------------------------------
// hog_buffer_reader
// Sweeps the HOG descriptor buffer from address 0 to N_FEAT-1 once the buffer
// signals a complete descriptor, and streams each bin with its feature index
// to the SVM dot-product unit over a valid/ready handshake.
//
// Ports
//   iClk    clock
//   iRst    synchronous active-high reset
//   iStart  descriptor-complete level; a rising edge starts a sweep
//   oADDR   buffer read address (combinational read port on the buffer)
//   iValue  buffer read data for oADDR, same cycle
//   oData   streamed bin value
//   oIdx    feature index of oData (SVM weight ROM address)
//   oValid  oData/oIdx/oLast valid
//   iReady  SVM accepts the presented word this cycle
//   oLast   presented word is the final feature
//   oBusy   sweep in progress
//   oDone   one-cycle pulse after the final word is accepted
//   oErr    sticky flag: start edge seen while a sweep was running
// -----------------------------------------------------------------------------
module hog_buffer_reader
   import hog_pkg::*;
#(
   parameter int N_FEAT = hog_pkg::N_FEAT,
   parameter int DATA_W = hog_pkg::DATA_W,
   parameter int ADDR_W = hog_pkg::ADDR_W
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iStart,
   output logic [ADDR_W-1:0] oADDR,
   input  logic [DATA_W-1:0] iValue,
   output logic [DATA_W-1:0] oData,
   output logic [ADDR_W-1:0] oIdx,
   output logic              oValid,
   input  logic              iReady,
   output logic              oLast,
   output logic              oBusy,
   output logic              oDone,
   output logic              oErr
);

   // One extra bit of headroom on the pointer so the last-index compare
   // uses the full constant without any truncation surprises.
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(N_FEAT - 1);

   hogState_t         state;
   hogState_t         stateNext;
   logic [ADDR_W:0]   rdPtr;
   logic              startQ;
   logic              startEdge;
   logic              load;
   logic              loadLast;
   logic              handshake;

   assign startEdge = iStart & ~startQ;
   assign handshake = oValid & iReady;
   // The output register refills whenever it is empty or being drained this
   // cycle, which gives one word per cycle with no bubble under iReady=1.
   assign load      = (state == STREAM) && (!oValid || iReady);
   assign loadLast  = load && (rdPtr == LAST_PTR);

   assign oADDR = rdPtr[ADDR_W-1:0];
   assign oBusy = (state != IDLE);

   // State register
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic: STREAM ends on loading the final word, DRAIN ends
   // when that final word is accepted downstream.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (startEdge)            stateNext = STREAM;
         STREAM:  if (loadLast)             stateNext = DRAIN;
         DRAIN:   if (handshake && oLast)   stateNext = IDLE;
         default:                           stateNext = IDLE;
      endcase
   end

   // Datapath: edge history, read pointer, output register and status flags.
   // The pointer parks on the last index instead of stepping past it, and is
   // returned to 0 when the sweep completes so oADDR idles at 0.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         startQ <= 1'b0;
         rdPtr  <= '0;
         oData  <= '0;
         oIdx   <= '0;
         oValid <= 1'b0;
         oLast  <= 1'b0;
         oDone  <= 1'b0;
         oErr   <= 1'b0;
      end else begin
         startQ <= iStart;
         oDone  <= 1'b0;

         if (startEdge && (state != IDLE)) begin
            oErr <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (startEdge) begin
                  rdPtr <= '0;
               end
            end
            STREAM: begin
               if (load) begin
                  oData  <= iValue;
                  oIdx   <= rdPtr[ADDR_W-1:0];
                  oValid <= 1'b1;
                  oLast  <= (rdPtr == LAST_PTR);
                  if (rdPtr != LAST_PTR) begin
                     rdPtr <= rdPtr + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (handshake && oLast) begin
                  oValid <= 1'b0;
                  oLast  <= 1'b0;
                  oDone  <= 1'b1;
                  rdPtr  <= '0;
               end
            end
            default: begin
               oValid <= 1'b0;
               oLast  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hog_buffer_reader.sv
// -----------------------------------------------------------------------------
// tb_hog_buffer_reader
// Directed bench for hog_buffer_reader. The buffer is modelled as a
// combinational ROM returning 32'hA000_0000 + address.
// -----------------------------------------------------------------------------
module tb_hog_buffer_reader;

   localparam int NF = 3780;

   logic        iClk;
   logic        iRst;
   logic        iStart;
   logic [11:0] oADDR;
   logic [31:0] iValue;
   logic [31:0] oData;
   logic [11:0] oIdx;
   logic        oValid;
   logic        iReady;
   logic        oLast;
   logic        oBusy;
   logic        oDone;
   logic        oErr;

   int          vectors;
   int          miscompares;
   int          clkCount;
   logic [15:0] lfsr;

   hog_buffer_reader dut (
      .iClk   (iClk),
      .iRst   (iRst),
      .iStart (iStart),
      .oADDR  (oADDR),
      .iValue (iValue),
      .oData  (oData),
      .oIdx   (oIdx),
      .oValid (oValid),
      .iReady (iReady),
      .oLast  (oLast),
      .oBusy  (oBusy),
      .oDone  (oDone),
      .oErr   (oErr)
   );

   assign iValue = 32'hA000_0000 + {20'd0, oADDR};

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   always @(posedge iClk) clkCount <= clkCount + 1;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic doReset();
      iRst   = 1'b1;
      iStart = 1'b0;
      iReady = 1'b1;
      tick();
      tick();
      iRst = 1'b0;
   endtask

   task automatic pulseStart();
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
   endtask

   // Follows one sweep cycle by cycle and tallies anomalies against an
   // expected word counter. readyMode: 0 = always ready, 1 = LFSR, 2 = stall
   // 10 cycles on the last word. secondStartAt/abortAt < 0 disables them.
   task automatic runStream(input int readyMode, input int secondStartAt, input int abortAt,
                            output int words, output int orderErrs, output int stallErrs,
                            output int lastErrs, output int gapErrs, output int doneCount,
                            output int doneLagErrs, output int busyErrs, output int tailErrs,
                            output int errSeqErrs, output bit timedOut);
      int cycles = 0;
      int tail = 0;
      int stallCnt = 0;
      bit prevStall = 0;
      bit lastAccPrev = 0;
      bit doneSeen = 0;
      bit errExp = 0;
      bit errNext = 0;
      bit secondDone = 0;
      bit endStart = 0;
      logic [31:0] prevData = '0;
      logic [11:0] prevIdx = '0;
      words = 0; orderErrs = 0; stallErrs = 0; lastErrs = 0; gapErrs = 0;
      doneCount = 0; doneLagErrs = 0; busyErrs = 0; tailErrs = 0; errSeqErrs = 0;
      timedOut = 0;
      forever begin
         if (cycles >= 20000) begin
            timedOut = 1;
            break;
         end
         case (readyMode)
            1: begin
               iReady = lfsr[0];
               lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            end
            2: begin
               if (oValid && oLast && stallCnt < 10) begin
                  iReady = 1'b0;
                  stallCnt++;
               end else begin
                  iReady = 1'b1;
               end
            end
            default: iReady = 1'b1;
         endcase
         if (endStart) begin
            iStart = 1'b0;
            endStart = 0;
         end
         if (lastAccPrev) doneSeen = 1;
         if (oErr !== errExp) errSeqErrs++;
         if (oBusy !== !doneSeen) busyErrs++;
         if (doneSeen && oValid !== 1'b0) tailErrs++;
         if (oDone !== lastAccPrev) doneLagErrs++;
         if (oDone === 1'b1) doneCount++;
         lastAccPrev = 0;
         if (!doneSeen && words > 0 && oValid !== 1'b1) gapErrs++;
         if (oValid === 1'b1) begin
            if (oIdx !== 12'(words) || oData !== (32'hA000_0000 + 32'(words))) orderErrs++;
            if (oLast !== (words == NF - 1)) lastErrs++;
            if (prevStall && (oData !== prevData || oIdx !== prevIdx)) stallErrs++;
         end
         if (abortAt >= 0 && oValid === 1'b1 && words == abortAt) begin
            iRst = 1'b1;
            break;
         end
         if (secondStartAt >= 0 && !secondDone && oValid === 1'b1 && words == secondStartAt) begin
            iStart = 1'b1;
            secondDone = 1;
            endStart = 1;
            errNext = 1;
         end
         prevStall = oValid && !iReady;
         prevData = oData;
         prevIdx = oIdx;
         if (oValid === 1'b1 && iReady) begin
            if (words == NF - 1) lastAccPrev = 1;
            words++;
         end
         if (doneSeen) begin
            tail++;
            if (tail > 3) break;
         end
         tick();
         cycles++;
         if (errNext) errExp = 1;
      end
   endtask

   // Reset values of every output
   task automatic test_reset();
      doReset();
      vectors++;
      if ({oADDR, oData, oIdx, oValid, oLast, oBusy, oDone, oErr} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got addr=%0h data=%0h idx=%0h v=%b l=%b b=%b d=%b e=%b, want all 0",
                  oADDR, oData, oIdx, oValid, oLast, oBusy, oDone, oErr);
      end
      tick();
      vectors++;
      if (oBusy !== 1'b0 || oValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_idle: got busy=%b valid=%b, want 0 0", oBusy, oValid);
      end
   endtask

   // Full sweep with iReady tied high, also first-word latency
   task automatic test_basic_sweep();
      int w, oe, se, le, ge, dc, dl, be, te, ee;
      bit to;
      doReset();
      pulseStart();
      vectors++;
      if (oBusy !== 1'b1 || oValid !== 1'b0 || oADDR !== 12'd0) begin
         miscompares++;
         $display("[TB] FAIL basic_e0: got busy=%b valid=%b addr=%0d, want 1 0 0", oBusy, oValid, oADDR);
      end
      runStream(0, -1, -1, w, oe, se, le, ge, dc, dl, be, te, ee, to);
      vectors++;
      if (to || w != NF) begin miscompares++; $display("[TB] FAIL basic_words: got %0d (timeout=%0b), want %0d", w, to, NF); end
      vectors++;
      if (oe != 0) begin miscompares++; $display("[TB] FAIL basic_order: got %0d bad words, want 0", oe); end
      vectors++;
      if (le != 0) begin miscompares++; $display("[TB] FAIL basic_last: got %0d bad oLast, want 0", le); end
      vectors++;
      if (ge != 0) begin miscompares++; $display("[TB] FAIL basic_gaps: got %0d gaps, want 0", ge); end
      vectors++;
      if (dc != 1 || dl != 0) begin miscompares++; $display("[TB] FAIL basic_done: got count=%0d misplaced=%0d, want 1 0", dc, dl); end
      vectors++;
      if (be != 0 || te != 0) begin miscompares++; $display("[TB] FAIL basic_busy_tail: got busyErr=%0d tailErr=%0d, want 0 0", be, te); end
      vectors++;
      if (oADDR !== 12'd0) begin miscompares++; $display("[TB] FAIL basic_addr_idle: got %0d, want 0", oADDR); end
   endtask

   // Random backpressure: same ordered stream, held data across stalls
   task automatic test_backpressure();
      int w, oe, se, le, ge, dc, dl, be, te, ee;
      bit to;
      doReset();
      lfsr = 16'hACE1;
      pulseStart();
      runStream(1, -1, -1, w, oe, se, le, ge, dc, dl, be, te, ee, to);
      vectors++;
      if (to || w != NF) begin miscompares++; $display("[TB] FAIL bp_words: got %0d (timeout=%0b), want %0d", w, to, NF); end
      vectors++;
      if (oe != 0 || ge != 0) begin miscompares++; $display("[TB] FAIL bp_order: got order=%0d gaps=%0d, want 0 0", oe, ge); end
      vectors++;
      if (se != 0) begin miscompares++; $display("[TB] FAIL bp_stall_hold: got %0d changes, want 0", se); end
      vectors++;
      if (dc != 1 || dl != 0 || le != 0) begin miscompares++; $display("[TB] FAIL bp_done_last: got done=%0d lag=%0d last=%0d, want 1 0 0", dc, dl, le); end
   endtask

   // Start held high: one sweep only, no error
   task automatic test_level_start();
      int w, oe, se, le, ge, dc, dl, be, te, ee, extra, t0;
      bit to;
      doReset();
      t0 = clkCount;
      iStart = 1'b1;
      tick();
      runStream(0, -1, -1, w, oe, se, le, ge, dc, dl, be, te, ee, to);
      extra = 0;
      while (clkCount - t0 < 5000) begin
         if (oValid !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) extra++;
         tick();
      end
      iStart = 1'b0;
      vectors++;
      if (to || w != NF || oe != 0) begin miscompares++; $display("[TB] FAIL level_sweep: got words=%0d order=%0d, want %0d 0", w, oe, NF); end
      vectors++;
      if (extra != 0) begin miscompares++; $display("[TB] FAIL level_retrigger: got %0d active cycles, want 0", extra); end
      vectors++;
      if (oErr !== 1'b0 || ee != 0) begin miscompares++; $display("[TB] FAIL level_err: got oErr=%b seqErr=%0d, want 0 0", oErr, ee); end
   endtask

   // Second start edge at word 100 sets sticky oErr, sweep unaffected
   task automatic test_start_while_busy();
      int w, oe, se, le, ge, dc, dl, be, te, ee;
      bit to;
      doReset();
      pulseStart();
      runStream(0, 100, -1, w, oe, se, le, ge, dc, dl, be, te, ee, to);
      vectors++;
      if (to || w != NF || oe != 0 || dc != 1) begin miscompares++; $display("[TB] FAIL busy_sweep: got words=%0d order=%0d done=%0d, want %0d 0 1", w, oe, dc, NF); end
      vectors++;
      if (ee != 0) begin miscompares++; $display("[TB] FAIL busy_err_timing: got %0d wrong oErr cycles, want 0", ee); end
      repeat (5) tick();
      vectors++;
      if (oErr !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_err_sticky: got %b, want 1", oErr); end
      doReset();
      vectors++;
      if (oErr !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_err_clear: got %b, want 0", oErr); end
   endtask

   // Reset at word 1500, then a fresh sweep from index 0
   task automatic test_reset_mid_sweep();
      int w, oe, se, le, ge, dc, dl, be, te, ee, doneSeen;
      bit to;
      doReset();
      pulseStart();
      runStream(0, -1, 1500, w, oe, se, le, ge, dc, dl, be, te, ee, to);
      vectors++;
      if (to || w != 1500 || oe != 0) begin miscompares++; $display("[TB] FAIL rst_prefix: got words=%0d order=%0d, want 1500 0", w, oe); end
      tick();
      vectors++;
      if ({oADDR, oData, oIdx, oValid, oLast, oBusy, oDone, oErr} !== '0) begin
         miscompares++;
         $display("[TB] FAIL rst_outputs: got addr=%0h data=%0h idx=%0h v=%b l=%b b=%b d=%b e=%b, want all 0",
                  oADDR, oData, oIdx, oValid, oLast, oBusy, oDone, oErr);
      end
      iRst = 1'b0;
      doneSeen = 0;
      repeat (8) begin
         tick();
         if (oDone !== 1'b0 || oValid !== 1'b0) doneSeen++;
      end
      vectors++;
      if (doneSeen != 0) begin miscompares++; $display("[TB] FAIL rst_no_done: got %0d active cycles, want 0", doneSeen); end
      pulseStart();
      runStream(0, -1, -1, w, oe, se, le, ge, dc, dl, be, te, ee, to);
      vectors++;
      if (to || w != NF || oe != 0 || dc != 1) begin miscompares++; $display("[TB] FAIL rst_restart: got words=%0d order=%0d done=%0d, want %0d 0 1", w, oe, dc, NF); end
   endtask

   // Hold the last word for 10 cycles; oDone waits for the handshake
   task automatic test_last_stall();
      int w, oe, se, le, ge, dc, dl, be, te, ee;
      bit to;
      doReset();
      pulseStart();
      runStream(2, -1, -1, w, oe, se, le, ge, dc, dl, be, te, ee, to);
      vectors++;
      if (to || w != NF || oe != 0) begin miscompares++; $display("[TB] FAIL laststall_words: got words=%0d order=%0d, want %0d 0", w, oe, NF); end
      vectors++;
      if (dc != 1 || dl != 0) begin miscompares++; $display("[TB] FAIL laststall_done: got count=%0d misplaced=%0d, want 1 0", dc, dl); end
      vectors++;
      if (se != 0 || le != 0 || be != 0) begin miscompares++; $display("[TB] FAIL laststall_hold: got hold=%0d last=%0d busy=%0d, want 0 0 0", se, le, be); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clkCount    = 0;
      lfsr        = 16'hACE1;
      iRst        = 1'b1;
      iStart      = 1'b0;
      iReady      = 1'b1;
      test_reset();
      test_basic_sweep();
      test_backpressure();
      test_level_start();
      test_start_while_busy();
      test_reset_mid_sweep();
      test_last_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
